// File: rtl/dmem_port_arbiter_pkg.sv
// Shared types and constants for the data-memory port arbiter.
// Slot 0 is the older issue slot and slot 1 is the younger one.
`timescale 1ns/1ps
package dmem_port_arbiter_pkg;

    // Arbiter FSM states. The top keeps its state in a plain logic vector,
    // so these are also exported below as sized constants.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [0:0] ST_IDLE    = IDLE;
    localparam logic [0:0] ST_RD_WAIT = RD_WAIT;

    // Longest memory read latency the counter can sequence.
    localparam int RD_LAT_MAX = 7;
    localparam int CNT_W      = 3;

    // Default bus widths of the core.
    localparam int DEF_AW = 32;
    localparam int DEF_DW = 32;

    // One LSU request as seen at the default widths of the core.
    typedef struct packed {
        logic              we;
        logic [DEF_AW-1:0] addr;
        logic [DEF_DW-1:0] wdata;
    } lsu_req_t;

    // Converts a slot index into its one-hot position on the 2-bit per-slot buses.
    function automatic logic [1:0] slot_onehot(input logic slot);
        return slot ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Bundle of the LSU request/response and memory-side signals of the arbiter.
// The slave modport is the arbiter's view; master is the core + memory view.
`timescale 1ns/1ps
interface dmem_port_arbiter_if #(
    parameter int AW = 32,
    parameter int DW = 32
);
    import dmem_port_arbiter_pkg::*;

    logic [1:0]         req_valid;
    logic [1:0]         req_we;
    logic [1:0][AW-1:0] req_addr;
    logic [1:0][DW-1:0] req_wdata;
    logic [1:0]         req_ready;

    logic [1:0]         resp_valid;
    logic [DW-1:0]      resp_rdata;

    logic               mem_en;
    logic               mem_we;
    logic [AW-1:0]      mem_addr;
    logic [DW-1:0]      mem_wdata;
    logic [DW-1:0]      mem_rdata;

    logic               busy;

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
        output req_ready, resp_valid, resp_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata, busy
    );

    modport master (
        output req_valid, req_we, req_addr, req_wdata, mem_rdata,
        input  req_ready, resp_valid, resp_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata, busy
    );

endinterface

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Two-way request picker: returns a one-hot grant among the valid slots.
// Ties go to slot 0 in fixed-priority mode, or to the slot that did not win
// last time in round-robin mode. Purely combinational.
`timescale 1ns/1ps
module rr_pick2
    import dmem_port_arbiter_pkg::*;
(
    input  logic [1:0] i_valid,
    input  logic       i_last,
    input  logic       i_rr_mode,
    output logic [1:0] o_grant
);

    // Pick a winner; a lone valid slot always wins regardless of history.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01:   o_grant = 2'b01;
            2'b10:   o_grant = 2'b10;
            2'b11:   o_grant = (i_rr_mode && !i_last) ? slot_onehot(1'b1) : slot_onehot(1'b0);
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/dmem_port_arbiter.sv
// Shares the single data-memory port between the two issue slots.
// Grants at most one load/store per cycle from IDLE. Stores complete with an
// ack the next cycle; loads park the arbiter in RD_WAIT for RD_LAT cycles,
// capture the memory data in the last one and return it the cycle after.
`timescale 1ns/1ps
module dmem_port_arbiter #(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int RD_LAT  = 1,
    parameter int RR_MODE = 0
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    dmem_port_arbiter_if.slave   io_bus
);
    import dmem_port_arbiter_pkg::*;

    // Out-of-range latencies are clamped so the counter can never wrap.
    localparam int LAT_EFF = (RD_LAT < 1) ? 1 :
                             ((RD_LAT > RD_LAT_MAX) ? RD_LAT_MAX : RD_LAT);
    localparam logic [CNT_W-1:0] LAT_INIT = CNT_W'(LAT_EFF);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [0:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic             r_owner;
    logic             r_last_grant;
    logic [1:0]       r_resp_valid;
    logic [DW-1:0]    r_resp_rdata;
    logic [AW-1:0]    r_mem_addr;
    logic [DW-1:0]    r_mem_wdata;

    logic [1:0]       w_pick;
    logic [1:0]       w_grant;
    logic             w_idle;
    logic             w_accept;
    logic             w_win;
    logic             w_win_we;
    logic [AW-1:0]    w_win_addr;
    logic [DW-1:0]    w_win_wdata;
    logic             w_rd_done;

    rr_pick2 u_pick (
        .i_valid   (io_bus.req_valid),
        .i_last    (r_last_grant),
        .i_rr_mode (RR_MODE != 0),
        .o_grant   (w_pick)
    );

    // Qualify the picker with the FSM (only IDLE accepts, nothing while in reset)
    // and mux out the winning slot's request fields.
    always_comb begin
        w_idle      = (r_state == ST_IDLE) && !i_reset;
        w_grant     = w_idle ? w_pick : 2'b00;
        w_accept    = |w_grant;
        w_win       = w_grant[1];
        w_win_we    = io_bus.req_we[w_win];
        w_win_addr  = io_bus.req_addr[w_win];
        w_win_wdata = io_bus.req_wdata[w_win];
        w_rd_done   = (r_state == ST_RD_WAIT) && (r_cnt <= CNT_ONE);
    end

    assign io_bus.req_ready  = w_grant;
    assign io_bus.mem_en     = w_accept;
    assign io_bus.mem_we     = w_accept & w_win_we;
    assign io_bus.mem_addr   = w_accept ? w_win_addr  : r_mem_addr;
    assign io_bus.mem_wdata  = w_accept ? w_win_wdata : r_mem_wdata;
    assign io_bus.resp_valid = r_resp_valid;
    assign io_bus.resp_rdata = r_resp_rdata;
    assign io_bus.busy       = (r_state == ST_RD_WAIT);

    // FSM and latency counter: a granted load enters RD_WAIT and counts down to the capture cycle.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_owner <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept && !w_win_we) begin
                        r_state <= ST_RD_WAIT;
                        r_cnt   <= LAT_INIT;
                        r_owner <= w_win;
                    end
                end
                ST_RD_WAIT: begin
                    r_cnt <= r_cnt - CNT_ONE;
                    if (w_rd_done) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Remember the last winner for round-robin ties; slot 1 after reset so slot 0 goes first.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_last_grant <= 1'b1;
        end else if (w_accept) begin
            r_last_grant <= w_win;
        end
    end

    // Hold the last driven address/data so the memory bus does not toggle on idle cycles.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else if (w_accept) begin
            r_mem_addr  <= w_win_addr;
            r_mem_wdata <= w_win_wdata;
        end
    end

    // Response register: one-cycle pulse for a load completion or a store ack.
    // Loads and stores can never complete together because RD_WAIT blocks new grants.
    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            r_resp_valid <= 2'b00;
            r_resp_rdata <= '0;
        end else if (w_rd_done) begin
            r_resp_valid <= slot_onehot(r_owner);
            r_resp_rdata <= io_bus.mem_rdata;
        end else if (w_accept && w_win_we) begin
            r_resp_valid <= w_grant;
            r_resp_rdata <= '0;
        end else begin
            r_resp_valid <= 2'b00;
        end
    end

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Scoreboard bench for dmem_port_arbiter. Two instances: A is fixed priority
// with a 1-cycle memory, B is round-robin with a 3-cycle memory. The memory
// model is a ROM returning addr*3 through a latency pipeline.
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

    localparam int LAT_A = 1;
    localparam int LAT_B = 3;

    typedef struct {
        int          inst;
        int          slot;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } memExp_t;

    typedef struct {
        int          inst;
        logic [1:0]  valid;
        logic [31:0] rdata;
    } respExp_t;

    typedef struct {
        int inst;
        int cyc;
    } respTime_t;

    logic clock;
    logic reset;
    int   checks;
    int   errors;
    int   cyc;

    memExp_t   memQ[$];
    respExp_t  respQ[$];
    respTime_t timeQ[$];

    logic [1:0]       dValid[2];
    logic [1:0]       dWe[2];
    logic [1:0][31:0] dAddr[2];
    logic [1:0][31:0] dWdata[2];
    logic [31:0]      memRdata[2];

    logic [1:0]  mReady[2];
    logic [1:0]  mResp[2];
    logic [31:0] mRdata[2];
    logic [31:0] mAddr[2];
    logic [31:0] mWdata[2];
    logic        mEn[2];
    logic        mWe[2];
    logic        mBusy[2];

    logic [31:0] pipeA;
    logic [31:0] pipeB[3];

    int bFrom[2];
    int bTo[2];

    dmem_port_arbiter_if #(.AW(32), .DW(32)) ifA ();
    dmem_port_arbiter_if #(.AW(32), .DW(32)) ifB ();

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT_A), .RR_MODE(0)) dutA (
        .i_clk   (clock),
        .i_reset (reset),
        .io_bus  (ifA)
    );

    dmem_port_arbiter #(.AW(32), .DW(32), .RD_LAT(LAT_B), .RR_MODE(1)) dutB (
        .i_clk   (clock),
        .i_reset (reset),
        .io_bus  (ifB)
    );

    assign ifA.req_valid = dValid[0];
    assign ifA.req_we    = dWe[0];
    assign ifA.req_addr  = dAddr[0];
    assign ifA.req_wdata = dWdata[0];
    assign ifA.mem_rdata = memRdata[0];
    assign ifB.req_valid = dValid[1];
    assign ifB.req_we    = dWe[1];
    assign ifB.req_addr  = dAddr[1];
    assign ifB.req_wdata = dWdata[1];
    assign ifB.mem_rdata = memRdata[1];

    assign mReady[0] = ifA.req_ready;
    assign mResp[0]  = ifA.resp_valid;
    assign mRdata[0] = ifA.resp_rdata;
    assign mAddr[0]  = ifA.mem_addr;
    assign mWdata[0] = ifA.mem_wdata;
    assign mEn[0]    = ifA.mem_en;
    assign mWe[0]    = ifA.mem_we;
    assign mBusy[0]  = ifA.busy;
    assign mReady[1] = ifB.req_ready;
    assign mResp[1]  = ifB.resp_valid;
    assign mRdata[1] = ifB.resp_rdata;
    assign mAddr[1]  = ifB.mem_addr;
    assign mWdata[1] = ifB.mem_wdata;
    assign mEn[1]    = ifB.mem_en;
    assign mWe[1]    = ifB.mem_we;
    assign mBusy[1]  = ifB.busy;

    // Free-running clock, 10 ns period.
    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Cycle counter used to time-stamp accepts and responses.
    always @(posedge clock) begin
        cyc <= cyc + 1;
    end

    function automatic logic [31:0] romRead(input logic [31:0] a);
        return a * 32'd3;
    endfunction

    // Memory model: a load's data appears exactly RD_LAT cycles after its access; filler elsewhere.
    always @(posedge clock) begin
        pipeA    <= (mEn[0] && !mWe[0]) ? romRead(mAddr[0]) : 32'hDEAD_BEEF;
        pipeB[0] <= (mEn[1] && !mWe[1]) ? romRead(mAddr[1]) : 32'hDEAD_BEEF;
        pipeB[1] <= pipeB[0];
        pipeB[2] <= pipeB[1];
    end

    assign memRdata[0] = pipeA;
    assign memRdata[1] = pipeB[2];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=%h expected=%h at cycle %0d", name, actual, expected, cyc);
        end
    endtask

    task automatic expectMem(input int inst, input int slot, input logic we,
                             input logic [31:0] addr, input logic [31:0] wdata);
        memQ.push_back('{inst: inst, slot: slot, we: we, addr: addr, wdata: wdata});
    endtask

    task automatic expectResp(input int inst, input logic [1:0] valid, input logic [31:0] rdata);
        respQ.push_back('{inst: inst, valid: valid, rdata: rdata});
    endtask

    // Drive one request on a slot, hold it until accepted; called and returns at posedge+1.
    task automatic applyStimulus(input int inst, input int slot, input logic we,
                                 input logic [31:0] addr, input logic [31:0] wdata,
                                 output int waited);
        logic took;
        took   = 1'b0;
        waited = 0;
        dWe[inst][slot]    = we;
        dAddr[inst][slot]  = addr;
        dWdata[inst][slot] = wdata;
        dValid[inst][slot] = 1'b1;
        for (int n = 0; n < 20 && !took; n++) begin
            @(negedge clock);
            took = mReady[inst][slot];
            @(posedge clock);
            #1;
            if (!took) waited++;
        end
        if (!took) begin
            checks++;
            errors++;
            $display("[TB] FAIL accept_timeout inst=%0d slot=%0d actual=not_ready expected=ready", inst, slot);
        end
        dValid[inst][slot] = 1'b0;
    endtask

    // Per-instance monitor step, run once per cycle at the falling edge.
    task automatic monitorInst(input int i);
        memExp_t   e;
        respExp_t  r;
        respTime_t t;
        int        lat;
        logic      expBusy;
        lat = (i == 0) ? LAT_A : LAT_B;
        if (reset) begin
            checkOutput($sformatf("rst_ready%0d", i), 32'(mReady[i]), 32'd0);
            checkOutput($sformatf("rst_mem_en%0d", i), 32'(mEn[i]), 32'd0);
            checkOutput($sformatf("rst_mem_we%0d", i), 32'(mWe[i]), 32'd0);
            checkOutput($sformatf("rst_resp%0d", i), 32'(mResp[i]), 32'd0);
            checkOutput($sformatf("rst_busy%0d", i), 32'(mBusy[i]), 32'd0);
            bFrom[i] = -1;
            bTo[i]   = -1;
            timeQ.delete();
            return;
        end
        expBusy = (cyc >= bFrom[i]) && (cyc <= bTo[i]);
        checkOutput($sformatf("busy%0d", i), 32'(mBusy[i]), 32'(expBusy));
        if (expBusy) begin
            checkOutput($sformatf("rdwait_ready%0d", i), 32'(mReady[i]), 32'd0);
            checkOutput($sformatf("rdwait_mem_en%0d", i), 32'(mEn[i]), 32'd0);
        end
        if (dValid[i] == 2'b00) begin
            checkOutput($sformatf("idle_ready%0d", i), 32'(mReady[i]), 32'd0);
            checkOutput($sformatf("idle_mem_en%0d", i), 32'(mEn[i]), 32'd0);
        end
        if (mEn[i]) begin
            if (memQ.size() == 0 || memQ[0].inst != i) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_mem inst=%0d actual=mem_en_1 addr=%h expected=no_access", i, mAddr[i]);
            end else begin
                e = memQ.pop_front();
                checkOutput($sformatf("grant_ready%0d", i), 32'(mReady[i]), 32'(1 << e.slot));
                checkOutput($sformatf("mem_we%0d", i), 32'(mWe[i]), 32'(e.we));
                checkOutput($sformatf("mem_addr%0d", i), mAddr[i], e.addr);
                checkOutput($sformatf("mem_wdata%0d", i), mWdata[i], e.wdata);
                timeQ.push_back('{inst: i, cyc: cyc + (e.we ? 1 : lat + 1)});
                if (!e.we) begin
                    bFrom[i] = cyc + 1;
                    bTo[i]   = cyc + lat;
                end
            end
        end
        if (mResp[i] != 2'b00) begin
            if (respQ.size() == 0 || respQ[0].inst != i) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_resp inst=%0d actual=%b expected=none", i, mResp[i]);
            end else begin
                r = respQ.pop_front();
                checkOutput($sformatf("resp_valid%0d", i), 32'(mResp[i]), 32'(r.valid));
                checkOutput($sformatf("resp_rdata%0d", i), mRdata[i], r.rdata);
                if (timeQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL resp_timing inst=%0d actual=cycle_%0d expected=no_pending", i, cyc);
                end else begin
                    t = timeQ.pop_front();
                    checkOutput($sformatf("resp_cycle%0d", i), 32'(cyc), 32'(t.cyc));
                end
            end
        end
    endtask

    // Monitor: compares DUT outputs against the scoreboard every falling edge.
    initial begin
        bFrom[0] = -1;
        bFrom[1] = -1;
        bTo[0]   = -1;
        bTo[1]   = -1;
        forever begin
            @(negedge clock);
            for (int i = 0; i < 2; i++) monitorInst(i);
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus with hand-computed expectations.
    initial begin
        int w0;
        int w1;
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        for (int i = 0; i < 2; i++) begin
            dValid[i] = 2'b00;
            dWe[i]    = 2'b00;
            dAddr[i]  = '0;
            dWdata[i] = '0;
        end
        #26;
        reset = 1'b0;
        repeat (2) begin
            @(posedge clock);
            #1;
        end

        $display("[TB] A: slot 0 store");
        expectMem(0, 0, 1'b1, 32'd44, 32'd36);
        expectResp(0, 2'b01, 32'd0);
        applyStimulus(0, 0, 1'b1, 32'd44, 32'd36, w0);

        $display("[TB] A: both slots store, fixed priority");
        expectMem(0, 0, 1'b1, 32'd12, 32'h11);
        expectMem(0, 1, 1'b1, 32'd44, 32'h22);
        expectResp(0, 2'b01, 32'd0);
        expectResp(0, 2'b10, 32'd0);
        fork
            applyStimulus(0, 0, 1'b1, 32'd12, 32'h11, w0);
            applyStimulus(0, 1, 1'b1, 32'd44, 32'h22, w1);
        join

        $display("[TB] A: slot 1 load with slot 0 store arriving during the wait");
        expectMem(0, 1, 1'b0, 32'd12, 32'd0);
        expectMem(0, 0, 1'b1, 32'd8, 32'd5);
        expectResp(0, 2'b10, 32'h24);
        expectResp(0, 2'b01, 32'd0);
        fork
            applyStimulus(0, 1, 1'b0, 32'd12, 32'd0, w1);
            begin
                @(posedge clock);
                #1;
                applyStimulus(0, 0, 1'b1, 32'd8, 32'd5, w0);
            end
        join
        repeat (3) begin
            @(posedge clock);
            #1;
        end

        $display("[TB] B: round-robin with both slots continuously valid");
        expectMem(1, 0, 1'b1, 32'h100, 32'd1);
        expectMem(1, 1, 1'b1, 32'h200, 32'd2);
        expectMem(1, 0, 1'b1, 32'h104, 32'd3);
        expectMem(1, 1, 1'b1, 32'h204, 32'd4);
        expectResp(1, 2'b01, 32'd0);
        expectResp(1, 2'b10, 32'd0);
        expectResp(1, 2'b01, 32'd0);
        expectResp(1, 2'b10, 32'd0);
        fork
            begin
                applyStimulus(1, 0, 1'b1, 32'h100, 32'd1, w0);
                applyStimulus(1, 0, 1'b1, 32'h104, 32'd3, w0);
            end
            begin
                applyStimulus(1, 1, 1'b1, 32'h200, 32'd2, w1);
                applyStimulus(1, 1, 1'b1, 32'h204, 32'd4, w1);
            end
        join
        repeat (2) begin
            @(posedge clock);
            #1;
        end

        $display("[TB] B: slot 1 load, three-cycle memory");
        expectMem(1, 1, 1'b0, 32'd20, 32'd0);
        expectResp(1, 2'b10, 32'h3C);
        applyStimulus(1, 1, 1'b0, 32'd20, 32'd0, w1);
        repeat (6) begin
            @(posedge clock);
            #1;
        end

        $display("[TB] B: reset during RD_WAIT aborts the load");
        expectMem(1, 0, 1'b0, 32'd20, 32'd0);
        applyStimulus(1, 0, 1'b0, 32'd20, 32'd0, w0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b0;
        repeat (6) begin
            @(posedge clock);
            #1;
        end
        expectMem(1, 0, 1'b0, 32'd16, 32'd0);
        expectResp(1, 2'b01, 32'h30);
        applyStimulus(1, 0, 1'b0, 32'd16, 32'd0, w0);
        checkOutput("post_reset_accept_wait", 32'(w0), 32'd0);
        repeat (6) begin
            @(posedge clock);
            #1;
        end

        checkOutput("mem_queue_drained", 32'(memQ.size()), 32'd0);
        checkOutput("resp_queue_drained", 32'(respQ.size()), 32'd0);
        checkOutput("timing_queue_drained", 32'(timeQ.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
